// File: rtl/regfile_bp_if.sv
// -----------------------------------------------------------------------------
// regfile_bp_if -- register-file access bundle
//
// Groups the two read ports, the write port and the ready flag of regfile_bp.
//   ren      : read enable, samples rs1/rs2 this cycle
//   rs1, rs2 : read register indices (5 bits, RV32 encoding)
//   rs1_val  : registered read data, port 1 (W bits)
//   rs2_val  : registered read data, port 2 (W bits)
//   wen      : write enable
//   rd       : write register index (5 bits)
//   rd_val   : write data (W bits)
//   ready    : high once the post-reset clear has completed
//
// Modports: master drives requests (pipeline side), slave is the register file.
// -----------------------------------------------------------------------------
interface regfile_bp_if #(
    parameter int W = 32
);
    logic         ren;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [W-1:0] rs1_val;
    logic [W-1:0] rs2_val;
    logic         wen;
    logic [4:0]   rd;
    logic [W-1:0] rd_val;
    logic         ready;

    modport master (
        output ren, rs1, rs2, wen, rd, rd_val,
        input  rs1_val, rs2_val, ready
    );

    modport slave (
        input  ren, rs1, rs2, wen, rd, rd_val,
        output rs1_val, rs2_val, ready
    );
endinterface

// File: rtl/regfile_bp.sv
// -----------------------------------------------------------------------------
// regfile_bp -- 2-read / 1-write architectural register file with optional
//               write-to-read bypass and a post-reset clear sequencer.
//
// Parameters:
//   W      : data width of every register and data port
//   NREG   : number of architectural registers (16 for RV32E, 32 otherwise)
//   BYPASS : 1 forwards a same-cycle write to the read outputs
//
// Ports:
//   clk    : single clock, rising-edge active
//   rst_n  : asynchronous active-low reset
//   bus    : regfile_bp_if.slave (ren/rs1/rs2 -> rs1_val/rs2_val,
//            wen/rd/rd_val write port, ready status)
//
// The storage array has no reset. After rst_n deasserts the CLEAR state walks
// the array writing zeros, one register per cycle (NREG cycles), then enters
// RUN and raises ready. Read data is registered (1-cycle latency). Register 0
// and indices >= NREG read as zero and ignore writes.
// -----------------------------------------------------------------------------
module regfile_bp #(
    parameter int W      = 32,
    parameter int NREG   = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_bp_if.slave  bus
);

    localparam int              AW   = $clog2(NREG);
    localparam logic [AW-1:0]   LAST = AW'(NREG - 1);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] clr_idx;
    logic [AW-1:0] clr_idx_next;

    logic [W-1:0]  regs [NREG];

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wdata;

    logic          rs1_hi_zero;
    logic          rs2_hi_zero;
    logic          rd_hi_zero;
    logic          rs1_ok;
    logic          rs2_ok;
    logic          rd_ok;
    logic          wr_live;
    logic [W-1:0]  rs1_next;
    logic [W-1:0]  rs2_next;
    logic [W-1:0]  rs1_q;
    logic [W-1:0]  rs2_q;

    // Indices beyond the array must not alias onto a real register, so the
    // unused upper index bits have to be zero for an access to be in range.
    generate
        if (AW < 5) begin : g_range
            assign rs1_hi_zero = (bus.rs1[4:AW] == '0);
            assign rs2_hi_zero = (bus.rs2[4:AW] == '0);
            assign rd_hi_zero  = (bus.rd[4:AW]  == '0);
        end else begin : g_full
            assign rs1_hi_zero = 1'b1;
            assign rs2_hi_zero = 1'b1;
            assign rd_hi_zero  = 1'b1;
        end
    endgenerate

    // "ok" means the index names a real, writable register (not x0, in range).
    assign rs1_ok  = rs1_hi_zero && (bus.rs1 != 5'd0);
    assign rs2_ok  = rs2_hi_zero && (bus.rs2 != 5'd0);
    assign rd_ok   = rd_hi_zero  && (bus.rd  != 5'd0);
    assign wr_live = bus.wen && rd_ok;

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_next;
            clr_idx <= clr_idx_next;
        end
    end

    // Next-state logic also owns the single storage write port: the clear
    // sequencer and the architectural write share it, selected by state.
    always_comb begin
        state_next   = state;
        clr_idx_next = clr_idx;
        mem_we       = 1'b0;
        mem_addr     = bus.rd[AW-1:0];
        mem_wdata    = bus.rd_val;
        unique case (state)
            CLEAR: begin
                mem_we       = 1'b1;
                mem_addr     = clr_idx;
                mem_wdata    = '0;
                clr_idx_next = clr_idx + 1'b1;
                if (clr_idx == LAST) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                mem_we = wr_live;
            end
        endcase
    end

    // Storage array: intentionally without reset; zeroed by the sequencer.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            regs[mem_addr] <= mem_wdata;
        end
    end

    // Read selection. The bypass compares the full 5-bit indices, and wr_live
    // already excludes x0 and out-of-range writes, so a discarded write is
    // never forwarded.
    always_comb begin
        rs1_next = '0;
        rs2_next = '0;
        if (BYPASS && wr_live && (bus.rd == bus.rs1)) begin
            rs1_next = bus.rd_val;
        end else if (rs1_ok) begin
            rs1_next = regs[bus.rs1[AW-1:0]];
        end
        if (BYPASS && wr_live && (bus.rd == bus.rs2)) begin
            rs2_next = bus.rd_val;
        end else if (rs2_ok) begin
            rs2_next = regs[bus.rs2[AW-1:0]];
        end
    end

    // Registered read outputs; forced to zero while clearing so that the
    // not-yet-initialised storage is never exposed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_q <= '0;
            rs2_q <= '0;
        end else if (state == CLEAR) begin
            rs1_q <= '0;
            rs2_q <= '0;
        end else if (bus.ren) begin
            rs1_q <= rs1_next;
            rs2_q <= rs2_next;
        end
    end

    assign bus.rs1_val = rs1_q;
    assign bus.rs2_val = rs2_q;
    assign bus.ready   = (state == RUN);

    // Once ready, it stays ready until the next reset.
    ready_sticky: assert property (@(posedge clk) disable iff (!rst_n)
        bus.ready |=> bus.ready);

    // While clearing, the read outputs hold zero.
    clear_outputs_zero: assert property (@(posedge clk) disable iff (!rst_n)
        !bus.ready |-> (rs1_q == '0 && rs2_q == '0));

endmodule

// File: tb/tb_regfile_bp.sv
// -----------------------------------------------------------------------------
// tb_regfile_bp -- self-checking bench for regfile_bp.
// Three instances share one stimulus stream:
//   a : NREG=32, BYPASS=1
//   b : NREG=32, BYPASS=0
//   c : NREG=16, BYPASS=1
// A behavioural model (array per instance + clear countdown) predicts the
// outputs every cycle; a vector table and hand sequences add fixed checks.
// -----------------------------------------------------------------------------
module tb_regfile_bp;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ren;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic         wen;
    logic [4:0]   rd;
    logic [W-1:0] rd_val;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_bp_if #(.W(W)) bus_a ();
    regfile_bp_if #(.W(W)) bus_b ();
    regfile_bp_if #(.W(W)) bus_c ();

    assign bus_a.ren = ren;  assign bus_a.rs1 = rs1;  assign bus_a.rs2 = rs2;
    assign bus_a.wen = wen;  assign bus_a.rd  = rd;   assign bus_a.rd_val = rd_val;
    assign bus_b.ren = ren;  assign bus_b.rs1 = rs1;  assign bus_b.rs2 = rs2;
    assign bus_b.wen = wen;  assign bus_b.rd  = rd;   assign bus_b.rd_val = rd_val;
    assign bus_c.ren = ren;  assign bus_c.rs1 = rs1;  assign bus_c.rs2 = rs2;
    assign bus_c.wen = wen;  assign bus_c.rd  = rd;   assign bus_c.rd_val = rd_val;

    regfile_bp #(.W(W), .NREG(32), .BYPASS(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    regfile_bp #(.W(W), .NREG(32), .BYPASS(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    regfile_bp #(.W(W), .NREG(16), .BYPASS(1'b1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    logic [W-1:0] out1 [3];
    logic [W-1:0] out2 [3];
    logic         rdy  [3];
    assign out1[0] = bus_a.rs1_val;  assign out2[0] = bus_a.rs2_val;  assign rdy[0] = bus_a.ready;
    assign out1[1] = bus_b.rs1_val;  assign out2[1] = bus_b.rs2_val;  assign rdy[1] = bus_b.ready;
    assign out1[2] = bus_c.rs1_val;  assign out2[2] = bus_c.rs2_val;  assign rdy[2] = bus_c.ready;

    // ---------------- behavioural reference model ----------------
    logic [W-1:0] mmem [3][32];
    logic [W-1:0] m1 [3];
    logic [W-1:0] m2 [3];
    int           clr_left [3];

    function automatic int nreg_of(int k);
        return (k == 2) ? 16 : 32;
    endfunction

    function automatic logic [W-1:0] model_read(int k, logic [4:0] idx);
        int n;
        bit wr_eff;
        n = nreg_of(k);
        wr_eff = wen && (rd != 5'd0) && (int'(rd) < n);
        if (k != 1 && wr_eff && rd == idx) return rd_val;
        if (idx == 5'd0 || int'(idx) >= n) return '0;
        return mmem[k][idx];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m1[k]       <= '0;
                m2[k]       <= '0;
                clr_left[k] <= nreg_of(k);
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (clr_left[k] > 0) begin
                    clr_left[k] <= clr_left[k] - 1;
                    m1[k] <= '0;
                    m2[k] <= '0;
                    if (clr_left[k] == 1)
                        for (int i = 0; i < 32; i++) mmem[k][i] <= '0;
                end else begin
                    if (ren) begin
                        m1[k] <= model_read(k, rs1);
                        m2[k] <= model_read(k, rs2);
                    end
                    if (wen && rd != 5'd0 && int'(rd) < nreg_of(k))
                        mmem[k][rd] <= rd_val;
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model();
        string tag [3] = '{"a", "b", "c"};
        for (int k = 0; k < 3; k++) begin
            check({"model_rs1_", tag[k]}, out1[k], m1[k]);
            check({"model_rs2_", tag[k]}, out2[k], m2[k]);
            check({"model_ready_", tag[k]}, W'(rdy[k]),
                  W'(rst_n && clr_left[k] == 0));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_model();
    endtask

    task automatic set_idle();
        ren = 1'b0; rs1 = '0; rs2 = '0;
        wen = 1'b0; rd = '0;  rd_val = '0;
    endtask

    task automatic check_zero_now(string name);
        for (int k = 0; k < 3; k++) begin
            check({name, "_rs1"}, out1[k], '0);
            check({name, "_rs2"}, out2[k], '0);
            check({name, "_ready"}, W'(rdy[k]), '0);
        end
    endtask

    // Called at the negedge where rst_n was just released; inputs as set by
    // the caller are held. Measures clear length and checks outputs stay 0.
    task automatic wait_ready(string tag);
        int ea = 0;
        int ec = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                if (!rdy[k]) begin
                    check({tag, "_clear_rs1_zero"}, out1[k], '0);
                    check({tag, "_clear_rs2_zero"}, out2[k], '0);
                end
            end
            if (rdy[0] && ea == 0) ea = c;
            if (rdy[2] && ec == 0) ec = c;
            if (ea != 0 && ec != 0) break;
        end
        check_int({tag, "_clear_cycles_n32"}, ea, 32);
        check_int({tag, "_clear_cycles_n16"}, ec, 16);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         ren;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic         wen;
        logic [4:0]   rd;
        logic [W-1:0] rd_val;
        logic [W-1:0] a1, a2, b1, b2, c1, c2;
    } vec_t;

    vec_t vecs [$];

    task automatic add(logic r, logic [4:0] s1, logic [4:0] s2, logic w, logic [4:0] d,
                       logic [W-1:0] v, logic [W-1:0] a1, logic [W-1:0] a2,
                       logic [W-1:0] b1, logic [W-1:0] b2, logic [W-1:0] c1, logic [W-1:0] c2);
        vec_t t;
        t.ren = r; t.rs1 = s1; t.rs2 = s2; t.wen = w; t.rd = d; t.rd_val = v;
        t.a1 = a1; t.a2 = a2; t.b1 = b1; t.b2 = b2; t.c1 = c1; t.c2 = c2;
        vecs.push_back(t);
    endtask

    localparam logic [W-1:0] DB = 32'hDEADBEEF;
    localparam logic [W-1:0] V7 = 32'h12345678;
    localparam logic [W-1:0] FF = 32'hFFFFFFFF;
    localparam logic [W-1:0] V1 = 32'h11111111;
    localparam logic [W-1:0] CF = 32'hCAFEF00D;
    localparam logic [W-1:0] TT = 32'h31313131;

    initial begin
        set_idle();
        // inputs: ren rs1 rs2 wen rd rd_val | expected a1 a2 b1 b2 c1 c2
        add(0,  0,  0, 1,  5, DB,            0,  0,  0,  0,  0,  0);
        add(1,  5,  0, 0,  0, 0,            DB,  0, DB,  0, DB,  0);
        add(1,  7,  7, 1,  7, V7,           V7, V7,  0,  0, V7, V7);
        add(1,  7,  5, 0,  0, 0,            V7, DB, V7, DB, V7, DB);
        add(0,  0,  0, 1, 20, FF,           V7, DB, V7, DB, V7, DB);
        add(1, 20,  4, 0,  0, 0,            FF,  0, FF,  0,  0,  0);
        add(1,  0,  0, 1,  0, 32'hAAAAAAAA,  0,  0,  0,  0,  0,  0);
        add(1,  0, 20, 0,  0, 0,             0, FF,  0, FF,  0,  0);
        add(1, 20,  7, 1, 20, V1,           V1, V7, FF, V7,  0, V7);
        add(1,  5,  7, 1,  7, CF,           DB, CF, DB, V7, DB, CF);
        add(0,  0,  0, 0,  0, 0,            DB, CF, DB, V7, DB, CF);
        add(1,  7, 20, 0,  0, 0,            CF, V1, CF, V1, CF,  0);
        add(0,  0,  0, 1, 31, TT,           CF, V1, CF, V1, CF,  0);
        add(1, 31, 15, 0,  0, 0,            TT,  0, TT,  0,  0,  0);

        // Power-on reset and first clear.
        repeat (3) @(negedge clk);
        check_model();
        check_zero_now("reset");
        rst_n = 1'b1;
        wait_ready("por");

        // Every register reads zero after the clear.
        for (int i = 0; i < 32; i++) begin
            ren = 1'b1; rs1 = 5'(i); rs2 = 5'(31 - i);
            tick();
            check("readall_rs1_a", out1[0], '0);
            check("readall_rs2_a", out2[0], '0);
        end

        // Table-driven vectors.
        foreach (vecs[r]) begin
            ren = vecs[r].ren; rs1 = vecs[r].rs1; rs2 = vecs[r].rs2;
            wen = vecs[r].wen; rd = vecs[r].rd;   rd_val = vecs[r].rd_val;
            tick();
            check($sformatf("vec%0d_a_rs1", r), out1[0], vecs[r].a1);
            check($sformatf("vec%0d_a_rs2", r), out2[0], vecs[r].a2);
            check($sformatf("vec%0d_b_rs1", r), out1[1], vecs[r].b1);
            check($sformatf("vec%0d_b_rs2", r), out2[1], vecs[r].b2);
            check($sformatf("vec%0d_c_rs1", r), out1[2], vecs[r].c1);
            check($sformatf("vec%0d_c_rs2", r), out2[2], vecs[r].c2);
        end

        // Mid-run reset, with reads/writes issued throughout the clear.
        set_idle(); wen = 1'b1; rd = 5'd3; rd_val = 32'hA5A5A5A5;
        tick();
        set_idle(); ren = 1'b1; rs1 = 5'd3; rs2 = 5'd3;
        tick();
        check("x3_before_reset", out1[0], 32'hA5A5A5A5);
        set_idle();
        #2 rst_n = 1'b0;
        #1 check_zero_now("midrun_reset");
        check_model();
        @(negedge clk);
        rst_n = 1'b1;
        ren = 1'b1; rs1 = 5'd3; rs2 = 5'd3; wen = 1'b1; rd = 5'd3; rd_val = 32'h1;
        wait_ready("midrun");
        set_idle(); ren = 1'b1; rs1 = 5'd3; rs2 = 5'd0;
        tick();
        check("x3_after_clear_a", out1[0], '0);
        check("x3_after_clear_b", out1[1], '0);

        // Reset asserted part-way through a clear restarts it from index 0.
        set_idle();
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) tick();
        #2 rst_n = 1'b0;
        #1 check_zero_now("midclear_reset");
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("midclear");

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            ren = 1'($urandom_range(0, 1));
            wen = 1'($urandom_range(0, 1));
            rd  = 5'($urandom_range(0, 31));
            rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            rs2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            rd_val = $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_bp.md
REGFILE_BP -- requirements
Module: regfile_bp

Interface
REQ-001 Parameter W, 32: data width in bits of every register and data port.
REQ-002 Parameter NREG, 32: number of architectural registers; legal values 16 (RV32E) and 32.
REQ-003 Parameter BYPASS, 1: when 1, a same-cycle write is forwarded to the read outputs; when 0, there is no forwarding.
REQ-004 clk  input  1  single clock; all state is updated on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 ren  input  1  read enable; samples rs1/rs2 this cycle.
REQ-007 rs1  input  5  read port 1 register index.
REQ-008 rs2  input  5  read port 2 register index.
REQ-009 rs1_val  output  W  registered read data, port 1.
REQ-010 rs2_val  output  W  registered read data, port 2.
REQ-011 wen  input  1  write enable.
REQ-012 rd  input  5  write register index.
REQ-013 rd_val  input  W  write data.
REQ-014 ready  output  1  high once the post-reset clear has completed; low while clearing.

Function
REQ-015 The block SHALL use one clock (clk) and an asynchronous, active-low reset (rst_n); the reset polarity and synchronicity are fixed.
REQ-016 The block SHALL hold NREG registers; the storage array carries no reset, so a clear sequencer zeroes it after reset.
REQ-017 FSM states SHALL be CLEAR and RUN; reset forces CLEAR with clear index 0.
REQ-018 In CLEAR, each cycle SHALL write 0 to register[index] and then increment index; the cycle that writes index NREG-1 SHALL transition to RUN.
REQ-019 The clear SHALL take exactly NREG cycles after rst_n deasserts; ready SHALL rise on the first cycle in RUN and stay high until the next reset.
REQ-020 In CLEAR, ren and wen SHALL be ignored and rs1_val/rs2_val SHALL hold 0.
REQ-021 In RUN, a read SHALL have a latency of 1 cycle: with ren=1 at edge N, rs1_val/rs2_val SHALL show the addressed data after edge N.
REQ-022 With ren=0, rs1_val and rs2_val SHALL hold their previous values.
REQ-023 Register 0 SHALL always read 0; writes with rd=0 SHALL be discarded.
REQ-024 Indices at or above NREG SHALL read 0, and writes to them SHALL be discarded, with no wrap-around and no aliasing.
REQ-025 In RUN, wen=1 SHALL write rd_val to register[rd] at the clock edge; a write SHALL be visible to a read issued on the following cycle.
REQ-026 If BYPASS=1, and ren, wen, rd==rsX and rd!=0 are all true in the same cycle, rsX_val SHALL take rd_val, not the stale stored value.
REQ-027 The bypass SHALL apply to both ports independently, including when rs1==rs2==rd.
REQ-028 If BYPASS=0, a same-cycle read of rd SHALL return the old stored value.
REQ-029 Simultaneous reads on both ports and a write SHALL all complete in one cycle, with no stall.

Reset
REQ-030 On rst_n low, rs1_val and rs2_val SHALL go to 0, ready to 0, state to CLEAR and the clear index to 0, immediately and without waiting for clk.
REQ-031 Reset asserted mid-clear or mid-run SHALL abort the current activity; the clear SHALL restart from index 0 after deassertion.
REQ-032 Storage contents SHALL be undefined between rst_n falling and the completion of the clear; no read SHALL expose them.

Verification
REQ-033 Reset release, NREG=32, idle inputs -> ready=0 for exactly 32 cycles, then 1; a read of every register returns 0.
REQ-034 Write x5=0xDEADBEEF, next cycle ren with rs1=5 and rs2=0 -> one cycle later rs1_val=0xDEADBEEF and rs2_val=0.
REQ-035 BYPASS=1, same cycle wen (rd=7, rd_val=0x12345678) and ren (rs1=7, rs2=7) -> both outputs 0x12345678; with BYPASS=0 both outputs return the old value 0.
REQ-036 NREG=16, write rd=20 with 0xFFFFFFFF, then read rs1=20 and rs1=4 -> both return 0.
REQ-037 Write x3=0xA5A5A5A5, assert rst_n low mid-run, release -> outputs 0 immediately, ready low for 32 cycles, then x3 reads 0.
REQ-038 Issue reads (rs1=3) and writes (rd=3, rd_val=0x1) during CLEAR -> ignored; outputs 0 throughout, and after ready rises x3 reads 0.
